stack_cpu: RTL and testbench
============================

STACK_CPU -- requirements
Module: stack_cpu

Interface
REQ-001 The block SHALL have these parameters: DATA_W, default 8, data and instruction width; ADDR_W, default 5, memory address and PC width; DEPTH, default 16, stack entries; legal only if DATA_W >= ADDR_W+3 and DEPTH >= 2.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 mem_req  out  1  memory transfer request.
REQ-005 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-006 mem_addr  out  ADDR_W  transfer address.
REQ-007 mem_wdata  out  DATA_W  write data.
REQ-008 mem_rdata  in  DATA_W  read data, sampled in the cycle mem_ready=1.
REQ-009 mem_ready  in  1  transfer completes in the cycle where mem_req=1 and mem_ready=1.
REQ-010 pc  out  ADDR_W  program counter.
REQ-011 depth  out  clog2(DEPTH+1)  current stack occupancy.
REQ-012 opc  out  3  opcode of the current instruction, equal to IR[DATA_W-1:DATA_W-3].
REQ-013 retire  out  1  one-cycle pulse when an instruction completes.
REQ-014 halted  out  1  core stopped on an error.
REQ-015 err  out  2  error code: 00 none, 01 underflow, 10 overflow.

Function
REQ-016 Instruction fields SHALL be: opcode = IR[DATA_W-1:DATA_W-3]; target = IR[ADDR_W-1:0].
REQ-017 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH target, 101 POP target, 110 JMP target, 111 JZ target.
REQ-018 The FSM states SHALL be FETCH, DECODE, POP_A, POP_B, EXEC, MEM_RD, MEM_WR, ERR.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready; then IR<=mem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_W), go to DECODE.
REQ-020 DECODE, ADD/SUB/AND: depth<2 -> ERR with err=01; else -> POP_A.
REQ-021 DECODE, NOT/POP: depth<1 -> ERR with err=01; else -> POP_A.
REQ-022 DECODE, PUSH: depth==DEPTH -> ERR with err=10; else -> MEM_RD.
REQ-023 DECODE, JMP: pc<=target, retire=1, -> FETCH.
REQ-024 DECODE, JZ: depth<1 -> ERR with err=01; else if TOS==0 then pc<=target; no pop; retire=1; -> FETCH.
REQ-025 POP_A: A<=TOS, depth-1; then ADD/SUB/AND -> POP_B, NOT -> EXEC, POP -> MEM_WR.
REQ-026 POP_B: B<=TOS, depth-1, -> EXEC.
REQ-027 EXEC: push result (ADD B+A, SUB B-A, AND B&A, NOT ~A), depth+1, retire=1, -> FETCH.
REQ-028 EXEC arithmetic SHALL be modulo 2^DATA_W, with no flags and no error on carry or borrow.
REQ-029 MEM_RD: mem_req=1, mem_we=0, mem_addr=target; on mem_ready push mem_rdata, depth+1, retire=1, -> FETCH.
REQ-030 MEM_WR: mem_req=1, mem_we=1, mem_addr=target, mem_wdata=A; on mem_ready retire=1, -> FETCH.
REQ-031 While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata SHALL stay stable.
REQ-032 mem_ready while mem_req=0 SHALL be ignored.
REQ-033 The stack SHALL be internal storage of DEPTH x DATA_W; TOS is the entry at index depth-1.
REQ-034 With depth==0, TOS is never read, because the DECODE checks prevent it.
REQ-035 Latency with mem_ready tied high SHALL be: ADD/SUB/AND 5 cycles, NOT 4, POP 4, PUSH 3, JMP/JZ 2 (FETCH entry to retire inclusive).
REQ-036 ERR: halted=1, err held, mem_req=0, pc/depth/stack frozen; leave only by reset.
REQ-037 In the error-detect cycle, pc keeps its post-fetch value and the stack is unmodified.

Reset
REQ-038 On rst=1 at a clock edge: state<=FETCH, pc<=0, depth<=0, IR/A/B<=0, halted<=0, err<=00, retire<=0, mem_req<=0, mem_we<=0, mem_addr<=0, mem_wdata<=0.
REQ-039 Reset SHALL take priority over every event, including an in-flight transfer with mem_ready=1 in the same cycle; that transfer is abandoned, with no push and no pc change.
REQ-040 Stack contents need not be cleared on reset.

Verification (DATA_W=8, ADDR_W=5, DEPTH=4, mem_ready=1 unless stated)
REQ-041 mem[0..3]=PUSH 10, PUSH 11, SUB, POP 12; mem[10]=7, mem[11]=5 -> mem[12]=2, depth=0, pc=4, four retire pulses.
REQ-042 PUSH values 200 and 100, then ADD, then POP -> stored value 44 (wrap), err=00.
REQ-043 TOS=0, JZ 20 -> pc=20 after 2 cycles, depth unchanged; TOS=3, JZ 20 -> pc=previous pc+1.
REQ-044 Five consecutive PUSH with DEPTH=4 -> err=10, halted=1, depth=4, pc=5, mem_req stays 0 thereafter.
REQ-045 One PUSH then ADD -> err=01, halted=1, depth=1.
REQ-046 mem_ready delayed 3 cycles in FETCH -> mem_req and mem_addr stable throughout; rst asserted on the 2nd wait cycle -> next cycle mem_req=0, pc=0, state FETCH.

Source files
------------

// File: rtl/stack_cpu.sv
// Stack-machine CPU core.
// Fetches one instruction per memory transfer, keeps an internal LIFO
// operand stack, and stops in an error state on stack under/overflow.
// All outputs are driven from registers. After reset the first FETCH cycle
// only raises the request. Every later entry into FETCH, MEM_RD or MEM_WR
// raises the request on the entering edge, so steady-state latency has no
// extra issue cycle.
module stack_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_ready,
    output logic [ADDR_W-1:0]              pc,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic [2:0]                     opc,
    output logic                           retire,
    output logic                           halted,
    output logic [1:0]                     err
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_POP_A  = 3'd2,
        S_POP_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM_RD = 3'd5,
        S_MEM_WR = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [DEPTH_W-1:0]  depth_q;
    logic [DATA_W-1:0]   ir_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                halted_q;
    logic [1:0]          err_q;
    logic                retire_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   stack_q [DEPTH];

    logic [2:0]          op_s;
    logic [ADDR_W-1:0]   target_s;
    logic [ADDR_W-1:0]   pc_inc_s;
    logic [IDX_W-1:0]    tos_idx_s;
    logic [IDX_W-1:0]    push_idx_s;
    logic [DATA_W-1:0]   tos_s;
    logic [DATA_W-1:0]   alu_d;

    assign op_s       = ir_q[DATA_W-1 -: 3];
    assign target_s   = ir_q[ADDR_W-1:0];
    assign pc_inc_s   = pc_q + ADDR_W'(1);
    assign tos_idx_s  = IDX_W'(depth_q - DEPTH_ONE);
    assign push_idx_s = IDX_W'(depth_q);
    assign tos_s      = stack_q[tos_idx_s];

    // ALU result: B is the deeper operand, A the former top of stack.
    always_comb begin
        alu_d = '0;
        case (op_s)
            OP_ADD:  alu_d = b_q + a_q;
            OP_SUB:  alu_d = b_q - a_q;
            OP_AND:  alu_d = b_q & a_q;
            OP_NOT:  alu_d = ~a_q;
            default: alu_d = '0;
        endcase
    end

    // Control FSM, datapath registers, stack storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            depth_q     <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            halted_q    <= 1'b0;
            err_q       <= ERR_NONE;
            retire_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (!mem_req_q) begin
                        // Issue cycle, only needed right after reset.
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        ir_q      <= mem_rdata;
                        pc_q      <= pc_inc_s;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op_s)
                        OP_ADD, OP_SUB, OP_AND: begin
                            if (depth_q < DEPTH_TWO) begin
                                err_q    <= ERR_UNDER;
                                halted_q <= 1'b1;
                                state_q  <= S_ERR;
                            end else begin
                                state_q <= S_POP_A;
                            end
                        end
                        OP_NOT, OP_POP: begin
                            if (depth_q < DEPTH_ONE) begin
                                err_q    <= ERR_UNDER;
                                halted_q <= 1'b1;
                                state_q  <= S_ERR;
                            end else begin
                                state_q <= S_POP_A;
                            end
                        end
                        OP_PUSH: begin
                            if (depth_q == DEPTH_FULL) begin
                                err_q    <= ERR_OVER;
                                halted_q <= 1'b1;
                                state_q  <= S_ERR;
                            end else begin
                                mem_req_q  <= 1'b1;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= target_s;
                                state_q    <= S_MEM_RD;
                            end
                        end
                        OP_JMP: begin
                            pc_q       <= target_s;
                            retire_q   <= 1'b1;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= target_s;
                            state_q    <= S_FETCH;
                        end
                        OP_JZ: begin
                            if (depth_q < DEPTH_ONE) begin
                                err_q    <= ERR_UNDER;
                                halted_q <= 1'b1;
                                state_q  <= S_ERR;
                            end else begin
                                if (tos_s == '0) begin
                                    pc_q       <= target_s;
                                    mem_addr_q <= target_s;
                                end else begin
                                    mem_addr_q <= pc_q;
                                end
                                retire_q  <= 1'b1;
                                mem_req_q <= 1'b1;
                                mem_we_q  <= 1'b0;
                                state_q   <= S_FETCH;
                            end
                        end
                        default: state_q <= S_ERR;
                    endcase
                end
                S_POP_A: begin
                    a_q     <= tos_s;
                    depth_q <= depth_q - DEPTH_ONE;
                    case (op_s)
                        OP_ADD, OP_SUB, OP_AND: state_q <= S_POP_B;
                        OP_NOT:                 state_q <= S_EXEC;
                        OP_POP: begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= target_s;
                            mem_wdata_q <= tos_s;
                            state_q     <= S_MEM_WR;
                        end
                        default: state_q <= S_ERR;
                    endcase
                end
                S_POP_B: begin
                    b_q     <= tos_s;
                    depth_q <= depth_q - DEPTH_ONE;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    stack_q[push_idx_s] <= alu_d;
                    depth_q    <= depth_q + DEPTH_ONE;
                    retire_q   <= 1'b1;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_q;
                    state_q    <= S_FETCH;
                end
                S_MEM_RD: begin
                    if (mem_ready) begin
                        stack_q[push_idx_s] <= mem_rdata;
                        depth_q    <= depth_q + DEPTH_ONE;
                        retire_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                        state_q    <= S_FETCH;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        retire_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                        state_q    <= S_FETCH;
                    end
                end
                S_ERR: begin
                    // Frozen until reset; only keep the bus idle.
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    halted_q  <= 1'b1;
                    state_q   <= S_ERR;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign depth     = depth_q;
    assign opc       = op_s;
    assign retire    = retire_q;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_stack_cpu.sv
// Directed self-checking bench for stack_cpu (DATA_W=8, ADDR_W=5, DEPTH=4).
module tb_stack_cpu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_req;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready = 1'b1;
    logic [4:0] pc;
    logic [2:0] depth;
    logic [2:0] opc;
    logic       retire;
    logic       halted;
    logic [1:0] err;

    logic [7:0] mem [32];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rcnt = 0;
    int rcyc [16];

    stack_cpu #(.DATA_W(8), .ADDR_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .depth(depth), .opc(opc), .retire(retire),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Memory model: write completes when request, write and ready coincide.
    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and log retire pulses.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (retire) begin
            if (rcnt < 16) rcyc[rcnt] = cyc;
            rcnt++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        cyc = 0;
        rcnt = 0;
    endtask

    task automatic run_retires(input int n, input int budget);
        int b;
        b = 0;
        while (rcnt < n && !halted && b < budget) begin
            tick();
            b++;
        end
        check_eq("retire_wait", rcnt, n);
    endtask

    task automatic run_halt(input int budget);
        int b;
        b = 0;
        while (!halted && b < budget) begin
            tick();
            b++;
        end
        check_eq("halt_wait", halted, 1);
    endtask

    initial begin
        int req_lo;
        // ---- reset state
        clear_mem();
        hold_reset();
        check_eq("rst_pc", pc, 0);
        check_eq("rst_depth", depth, 0);
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_retire", retire, 0);
        check_eq("rst_opc", opc, 0);

        // ---- PUSH/PUSH/SUB/POP with latencies
        mem[0] = 8'h8A; mem[1] = 8'h8B; mem[2] = 8'h20; mem[3] = 8'hAC; mem[4] = 8'hC4;
        mem[10] = 8'd7; mem[11] = 8'd5;
        release_reset();
        run_retires(4, 60);
        check_eq("sub_mem12", mem[12], 2);
        check_eq("sub_depth", depth, 0);
        check_eq("sub_pc", pc, 4);
        check_eq("lat_push", rcyc[1] - rcyc[0], 3);
        check_eq("lat_sub", rcyc[2] - rcyc[1], 5);
        check_eq("lat_pop", rcyc[3] - rcyc[2], 4);

        // ---- ADD wraps modulo 256
        hold_reset();
        clear_mem();
        mem[0] = 8'h8A; mem[1] = 8'h8B; mem[2] = 8'h00; mem[3] = 8'hAC; mem[4] = 8'hC4;
        mem[10] = 8'd200; mem[11] = 8'd100;
        release_reset();
        run_retires(4, 60);
        check_eq("add_wrap", mem[12], 44);
        check_eq("add_err", err, 0);

        // ---- AND then NOT, NOT latency
        hold_reset();
        clear_mem();
        mem[0] = 8'h8A; mem[1] = 8'h8B; mem[2] = 8'h40; mem[3] = 8'h60; mem[4] = 8'hAC; mem[5] = 8'hC5;
        mem[10] = 8'hF0; mem[11] = 8'h3C;
        release_reset();
        run_retires(5, 80);
        check_eq("and_not", mem[12], 8'hCF);
        check_eq("lat_not", rcyc[3] - rcyc[2], 4);

        // ---- JZ taken with TOS=0
        hold_reset();
        clear_mem();
        mem[0] = 8'h8A; mem[1] = 8'hF4; mem[20] = 8'hD4; mem[10] = 8'd0;
        release_reset();
        run_retires(2, 40);
        check_eq("jz_taken_pc", pc, 20);
        check_eq("jz_taken_depth", depth, 1);
        check_eq("lat_jz", rcyc[1] - rcyc[0], 2);

        // ---- JZ not taken with TOS=3
        hold_reset();
        clear_mem();
        mem[0] = 8'h8A; mem[1] = 8'hF4; mem[2] = 8'hC2; mem[20] = 8'hD4; mem[10] = 8'd3;
        release_reset();
        run_retires(2, 40);
        check_eq("jz_fall_pc", pc, 2);
        check_eq("jz_fall_depth", depth, 1);
        run_retires(3, 20);
        check_eq("lat_jmp", rcyc[2] - rcyc[1], 2);

        // ---- overflow on fifth PUSH
        hold_reset();
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = 8'h8A;
        mem[10] = 8'd9;
        release_reset();
        run_halt(80);
        check_eq("ovf_err", err, 2);
        check_eq("ovf_depth", depth, 4);
        check_eq("ovf_pc", pc, 5);
        req_lo = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_req) req_lo++;
        end
        check_eq("ovf_req_idle", req_lo, 0);
        check_eq("ovf_halted_held", halted, 1);
        check_eq("ovf_pc_frozen", pc, 5);

        // ---- underflow on ADD with one entry
        hold_reset();
        clear_mem();
        mem[0] = 8'h8A; mem[1] = 8'h00; mem[10] = 8'd1;
        release_reset();
        run_halt(40);
        check_eq("unf_err", err, 1);
        check_eq("unf_depth", depth, 1);
        check_eq("unf_pc", pc, 2);

        // ---- stalled fetch, reset on second wait cycle abandons it
        hold_reset();
        clear_mem();
        mem[0] = 8'h8A; mem[1] = 8'hC1; mem[10] = 8'd6;
        mem_ready = 1'b0;
        release_reset();
        tick();
        check_eq("stall1_req", mem_req, 1);
        check_eq("stall1_addr", mem_addr, 0);
        check_eq("stall1_we", mem_we, 0);
        tick();
        check_eq("stall2_req", mem_req, 1);
        check_eq("stall2_addr", mem_addr, 0);
        rst = 1'b1;
        mem_ready = 1'b1;
        tick();
        check_eq("abort_req", mem_req, 0);
        check_eq("abort_pc", pc, 0);
        check_eq("abort_depth", depth, 0);
        check_eq("abort_opc", opc, 0);
        release_reset();
        run_retires(1, 20);
        check_eq("restart_depth", depth, 1);
        check_eq("restart_pc", pc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
